// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the EX-stage ALU/MDU.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,  OP_SUB   = 5'd1,  OP_SLT   = 5'd2,  OP_SLTU  = 5'd3,
        OP_AND   = 5'd4,  OP_OR    = 5'd5,  OP_NOR   = 5'd6,  OP_XOR   = 5'd7,
        OP_SLL   = 5'd8,  OP_SRL   = 5'd9,  OP_SRA   = 5'd10, OP_EQ    = 5'd11,
        OP_SGE   = 5'd12, OP_SGEU  = 5'd13,
        OP_MUL   = 5'd16, OP_MULH  = 5'd17, OP_MULHU = 5'd18,
        OP_DIV   = 5'd20, OP_DIVU  = 5'd21, OP_REM   = 5'd22, OP_REMU  = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

    function automatic logic is_mul(input alu_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHU};
    endfunction

    function automatic logic is_div(input alu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle integer datapath; one adder serves ADD, SUB and all compares.
module alu_comb
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  alu_op_e        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   y
);
    localparam int SHW = $clog2(W);

    logic           sub;
    logic [W:0]     sum;
    logic           ltu, lts, eq;
    logic [SHW-1:0] sh;

    // Everything except ADD runs the adder as a - b; carry-out clear means a < b unsigned.
    assign sub = (op != OP_ADD);
    assign sum = {1'b0, a} + {1'b0, b ^ {W{sub}}} + {{W{1'b0}}, sub};
    assign ltu = ~sum[W];
    assign lts = (a[W-1] ^ b[W-1]) ? a[W-1] : sum[W-1];
    assign eq  = (sum[W-1:0] == '0);
    assign sh  = b[SHW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_ADD, OP_SUB: y = sum[W-1:0];
            OP_SLT:  y = {{(W-1){1'b0}}, lts};
            OP_SLTU: y = {{(W-1){1'b0}}, ltu};
            OP_SGE:  y = {{(W-1){1'b0}}, ~lts};
            OP_SGEU: y = {{(W-1){1'b0}}, ~ltu};
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << sh;
            OP_SRL:  y = a >> sh;
            OP_SRA:  y = $signed(a) >>> sh;
            OP_EQ:   y = {{(W-1){1'b0}}, eq};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage execute unit: 1-cycle ALU ops plus W-cycle shift-add multiply and
// restoring divide, with a registered valid/ready result and flush.
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int W   = 32,
    localparam int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [4:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         busy
);
    state_e         state;
    alu_op_e        op_in, op_q;
    logic [SHW-1:0] cnt;
    logic [W-1:0]   hi, lo, opnd;
    logic           neg, rneg;
    logic           accept, sgn;
    logic [W-1:0]   a_mag, b_mag, y_comb;

    assign op_in     = alu_op_e'(op);
    assign busy      = (state == MUL) || (state == DIV);
    assign out_valid = (state == DONE);
    assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;

    alu_comb #(.W(W)) u_comb (.op(op_in), .a(a), .b(b), .y(y_comb));

    // Iterate on magnitudes; signs are reapplied once the last step completes.
    assign sgn   = is_mul(op_in) ? (op_in != OP_MULHU) : (op_in inside {OP_DIV, OP_REM});
    assign a_mag = (sgn && a[W-1]) ? -a : a;
    assign b_mag = (sgn && b[W-1]) ? -b : b;

    logic [W:0]     msum, dsh, dtr;
    logic [W-1:0]   nxt_hi, nxt_lo, quo_f, rem_f, fin_y;
    logic [2*W-1:0] prod, prod_f;

    always_comb begin
        // {hi,lo} is the product/multiplier pair for MUL and the remainder/dividend pair for DIV.
        msum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        dsh  = {hi, lo[W-1]};
        dtr  = dsh - {1'b0, opnd};
        if (state == MUL) begin
            nxt_hi = msum[W:1];
            nxt_lo = {msum[0], lo[W-1:1]};
        end else begin
            nxt_hi = dtr[W] ? dsh[W-1:0] : dtr[W-1:0];
            nxt_lo = {lo[W-2:0], ~dtr[W]};
        end
        prod   = {nxt_hi, nxt_lo};
        prod_f = neg ? -prod : prod;
        quo_f  = neg ? -nxt_lo : nxt_lo;
        rem_f  = rneg ? -nxt_hi : nxt_hi;
        case (op_q)
            OP_MUL:             fin_y = prod_f[W-1:0];
            OP_MULH, OP_MULHU:  fin_y = prod_f[2*W-1:W];
            OP_REM, OP_REMU:    fin_y = rem_f;
            default:            fin_y = quo_f;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            neg   <= 1'b0;
            rneg  <= 1'b0;
            y     <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q <= op_in;
                        cnt  <= '0;
                        hi   <= '0;
                        if (is_mul(op_in)) begin
                            lo    <= b_mag;
                            opnd  <= a_mag;
                            neg   <= sgn && (a[W-1] ^ b[W-1]);
                            state <= MUL;
                        end else if (is_div(op_in)) begin
                            lo    <= a_mag;
                            opnd  <= b_mag;
                            // Divide-by-zero keeps the all-ones quotient unsigned.
                            neg   <= sgn && (a[W-1] ^ b[W-1]) && (b != '0);
                            rneg  <= sgn && a[W-1];
                            state <= DIV;
                        end else begin
                            y     <= y_comb;
                            state <= DONE;
                        end
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                MUL, DIV: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == SHW'(W - 1)) begin
                        y     <= fin_y;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed check of alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [4:0]  op;
    logic [31:0] a, b, y;

    int errs   = 0;
    int checks = 0;

    alu_mdu #(.W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] z);
        int          ix, iz;
        longint      sp;
        logic [63:0] pv;
        ix = int'(x);
        iz = int'(z);
        case (o)
            5'd0:  return x + z;
            5'd1:  return x - z;
            5'd2:  return 32'(ix < iz);
            5'd3:  return 32'(x < z);
            5'd4:  return x & z;
            5'd5:  return x | z;
            5'd6:  return ~(x | z);
            5'd7:  return x ^ z;
            5'd8:  return x << z[4:0];
            5'd9:  return x >> z[4:0];
            5'd10: return 32'(ix >>> z[4:0]);
            5'd11: return 32'(x == z);
            5'd12: return 32'(ix >= iz);
            5'd13: return 32'(x >= z);
            5'd16, 5'd17: begin
                sp = longint'(ix) * longint'(iz);
                pv = sp;
                return (o == 5'd16) ? pv[31:0] : pv[63:32];
            end
            5'd18: begin
                pv = {32'b0, x} * {32'b0, z};
                return pv[63:32];
            end
            5'd20: return (z == 0) ? 32'hFFFF_FFFF :
                          (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) ? x : 32'(ix / iz);
            5'd21: return (z == 0) ? 32'hFFFF_FFFF : x / z;
            5'd22: return (z == 0) ? x :
                          (x == 32'h8000_0000 && z == 32'hFFFF_FFFF) ? 32'd0 : 32'(ix % iz);
            5'd23: return (z == 0) ? x : x % z;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat_of(input logic [4:0] o);
        return (o inside {[5'd16:5'd18], [5'd20:5'd23]}) ? 33 : 1;
    endfunction

    // One op with out_ready high: latency, busy length and result are all checked.
    task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x, input logic [31:0] z);
        int n, nb;
        logic [31:0] exp;
        exp = model(o, x, z);
        @(negedge clk);
        op = o; a = x; b = z; in_valid = 1'b1; out_ready = 1'b1;
        chk({tag, " rdy"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
        n = 0; nb = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (out_valid || n > 100) break;
        end
        chk({tag, " lat"}, 64'(n), 64'(lat_of(o)));
        chk({tag, " busy"}, 64'(nb), 64'(lat_of(o) - 1));
        chk({tag, " y"}, 64'(y), 64'(exp));
    endtask

    logic [4:0]  ops[24] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                             5'd10, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17, 5'd18, 5'd20,
                             5'd21, 5'd22, 5'd23, 5'd19, 5'd25, 5'd31};
    logic [31:0] edge_vals[6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    function automatic logic [31:0] rnd_operand();
        if ($urandom_range(3) == 0) return edge_vals[$urandom_range(5)];
        if ($urandom_range(3) == 0) return 32'($urandom_range(20));
        return $urandom;
    endfunction

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst y", 64'(y), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);

        run_op("add ovf", 5'd0, 32'h7FFF_FFFF, 32'd1);
        chk("add ovf lit", 64'(y), 64'h8000_0000);
        run_op("slt", 5'd2, 32'hFFFF_FFFF, 32'd0);
        run_op("sltu", 5'd3, 32'hFFFF_FFFF, 32'd0);
        run_op("mulh min", 5'd17, 32'h8000_0000, 32'h8000_0000);
        chk("mulh lit", 64'(y), 64'h4000_0000);
        run_op("mul neg", 5'd16, 32'd7, 32'hFFFF_FFFD);
        run_op("div neg", 5'd20, 32'hFFFF_FFF9, 32'd2);
        chk("div lit", 64'(y), 64'hFFFF_FFFD);
        run_op("rem neg", 5'd22, 32'hFFFF_FFF9, 32'd2);
        run_op("divu z", 5'd21, 32'd5, 32'd0);
        run_op("rem z", 5'd22, 32'd5, 32'd0);
        chk("rem z lit", 64'(y), 64'd5);
        run_op("div ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("undef", 5'd19, 32'd9, 32'd9);

        // Back-to-back simple ops: a result on each of three consecutive cycles.
        @(negedge clk);
        op = 5'd7; a = 32'h1234_5678; b = 32'h0F0F_F0F0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b xor v", 64'(out_valid), 64'd1);
        chk("b2b xor y", 64'(y), 64'(32'h1234_5678 ^ 32'h0F0F_F0F0));
        chk("b2b rdy", 64'(in_ready), 64'd1);
        op = 5'd10; a = 32'h8000_0000; b = 32'd4;
        @(posedge clk);
        @(negedge clk);
        chk("b2b sra v", 64'(out_valid), 64'd1);
        chk("b2b sra y", 64'(y), 64'hF800_0000);
        op = 5'd11; a = 32'hCAFE_0001; b = 32'hCAFE_0001;
        @(posedge clk);
        @(negedge clk);
        chk("b2b eq v", 64'(out_valid), 64'd1);
        chk("b2b eq y", 64'(y), 64'd1);
        in_valid = 1'b0;

        // Backpressure: result holds while out_ready is low.
        @(negedge clk);
        out_ready = 1'b0; op = 5'd0; a = 32'd2; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 op = 5'd1; a = 32'd10; b = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp v", 64'(out_valid), 64'd1);
            chk("bp y", 64'(y), 64'd5);
            chk("bp rdy", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1 chk("bp release rdy", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp next v", 64'(out_valid), 64'd1);
        chk("bp next y", 64'(y), 64'd7);

        // Flush mid-divide with a competing op on the same cycle.
        @(negedge clk);
        op = 5'd21; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
        #1;
        chk("flush rdy", 64'(in_ready), 64'd0);
        chk("flush busy pre", 64'(busy), 64'd1);
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush busy", 64'(busy), 64'd0);
        chk("flush v", 64'(out_valid), 64'd0);
        chk("flush y kept", 64'(y), 64'd7);
        chk("flush idle rdy", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        chk("flush no accept", 64'(out_valid), 64'd0);

        // Reset mid-multiply.
        @(negedge clk);
        op = 5'd16; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst busy", 64'(busy), 64'd0);
        chk("mrst v", 64'(out_valid), 64'd0);
        chk("mrst y", 64'(y), 64'd0);
        chk("mrst rdy", 64'(in_ready), 64'd1);

        for (int i = 0; i < 150; i++)
            run_op("rand", ops[$urandom_range(23)], rnd_operand(), rnd_operand());

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised, handshaked execute unit for the pipeline CPU's EX stage.
- Performs all single-cycle integer ops: add/sub, compares, logic, shifts.
- Adds iterative multiply and divide/remainder, with registered output and valid/ready flow control so EX can stall on long ops.
- Provides a flush input for branch mispredict and exception kill.

Parameters:
- W, 32: datapath width in bits; must be a power of two and ≥ 8.
- SHW, $clog2(W): shift-amount width (derived, not overridable).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset. One clock; reset is synchronous and active-high.
- flush, input, 1: synchronous kill of the in-flight op and any held result.
- in_valid, input, 1: op/a/b valid.
- in_ready, output, 1: unit can accept an op this cycle.
- op, input, 5: operation code (alu_pkg::alu_op_e).
- a, input, W: operand A (rs1).
- b, input, W: operand B (rs2/imm).
- out_valid, output, 1: y holds a completed result.
- out_ready, input, 1: consumer takes y this cycle.
- y, output, W: result.
- busy, output, 1: multiply or divide iteration in progress.

Behaviour:
- Reset: state=IDLE; out_valid=0, busy=0, y=0; in_ready=1 from the first cycle after reset.
- States:
  - IDLE: no op held.
  - MUL / DIV: iterating.
  - DONE: result held, out_valid=1.
- Accept: handshake occurs when in_valid & in_ready.
  - in_ready = !flush & (IDLE | (DONE & out_ready)).
  - This gives back-to-back throughput of 1 op/cycle for simple ops.
- Simple ops: result is registered into y at the accept edge and the unit goes to DONE. Latency 1, so out_valid is seen the cycle after accept.
  - ADD, SUB: modulo 2^W.
  - SLT (signed), SLTU, SGE (signed), SGEU: result is {W-1 zeros, bit}.
  - AND, OR, NOR, XOR: bitwise.
  - SLL, SRL, SRA: shift amount is b[SHW-1:0]; SRA sign-fills.
  - EQ: result is 1 if a==b, else 0.
  - Undefined op codes: result 0, latency 1.
- MUL, MULH, MULHU: radix-2 shift-add over a 2W-bit product. Exactly W iteration cycles in MUL, then DONE.
  - out_valid asserts W+1 cycles after the accept edge.
  - MUL returns product[W-1:0].
  - MULH (signed×signed) and MULHU (unsigned) return product[2W-1:W].
  - Signed handling: operand magnitudes are taken at accept; the product is negated at completion when the signs differ.
- DIV, DIVU, REM, REMU: restoring division, W iteration cycles in DIV, then DONE. Same latency as MUL.
  - Signed ops: quotient is negated if the operand signs differ; remainder takes the sign of a (truncating division).
  - b==0: quotient = all ones; remainder = a. Same latency as normal.
  - Signed overflow (a=-2^(W-1), b=-1): quotient = a; remainder = 0.
- busy=1 exactly in states MUL and DIV. in_ready=0 while busy.
- DONE with out_ready=0: y and out_valid are held stable and unchanged.
- DONE with out_ready=1 and no new accept: next state is IDLE and out_valid drops.
- flush:
  - Forces IDLE next cycle and clears out_valid and busy; y is not cleared.
  - Same-cycle in_valid is not accepted.
  - rst has priority over flush.
- Reset or flush mid-iteration abandons the op. No partial result is ever presented.
- Operands are captured at accept; a and b may change freely afterwards.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_e enum with encodings ADD=0, SUB=1, SLT=2, SLTU=3, AND=4, OR=5, NOR=6, XOR=7, SLL=8, SRL=9, SRA=10, EQ=11, SGE=12, SGEU=13, MUL=16, MULH=17, MULHU=18, DIV=20, DIVU=21, REM=22, REMU=23.
  - state_e enum {IDLE, MUL, DIV, DONE}.
  - Helper functions is_mul(op) and is_div(op).
- One sub-module, alu_comb #(W): purely combinational simple-op datapath using a shared adder with invert-B + carry-in for SUB and compares.
- alu_mdu owns the FSM, the iteration counter, the mul/div shift registers, sign fix-up and the output register.

Test Plan (all with W=32):
- Reset, then ADD a=0x7FFFFFFF, b=1 with out_ready=1 → out_valid the next cycle, y=0x80000000; SLT a=0xFFFFFFFF, b=0 → y=1; SLTU with the same operands → y=0.
- MULH a=0x80000000, b=0x80000000 → busy high for 32 cycles, out_valid on cycle 33 after accept, y=0x40000000; MUL a=7, b=-3 → y=0xFFFFFFEB.
- DIV a=-7, b=2 → y=0xFFFFFFFD; REM with the same operands → y=0xFFFFFFFF; DIVU a=5, b=0 → y=0xFFFFFFFF; REM a=5, b=0 → y=5; DIV a=0x80000000, b=-1 → y=0x80000000.
- Back-to-back simple ops with out_ready=1: XOR, SRA (a=0x80000000, b=4), EQ (a=b) on consecutive accepts → y=a^b, then 0xF8000000, then 1 on three consecutive cycles with no bubble.
- Backpressure: complete ADD 2+3 with out_ready=0 for 5 cycles → y=5 and out_valid held stable, in_ready=0 throughout; raise out_ready → a new op is accepted that same cycle.
- Flush at iteration 10 of a DIVU, with in_valid high that cycle → next cycle IDLE, busy=0, out_valid=0, the same-cycle op is not accepted; rst asserted mid-MUL → same idle state and y=0.
